// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use bubbles, taken-branch flush, data-memory wait/timeout FSM.
// Optional HAZ_STALL_CNT_EN adds a saturating 16-bit StallCount output.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] IFID_Rs,
  input  logic [4:0] IFID_Rt,
  input  logic [1:0] IDEX_MemRead,
  input  logic [4:0] IDEX_Rt,
  input  logic       BranchTaken,
  input  logic [1:0] EXMEM_MemRead,
  input  logic [1:0] EXMEM_MemWrite,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       IFIDWrite,
  output logic       IFIDFlush,
  output logic       IDEXBubble,
  output logic       IDEXHold,
  output logic       EXMEMHold,
  output logic       MemError,
  output logic [1:0] State
`ifdef HAZ_STALL_CNT_EN
  ,
  output logic [15:0] StallCount
`endif
);

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;

  logic [1:0] state_q, state_d;
  logic [7:0] cnt_q, cnt_d, cnt_inc;
  logic       access, pending, load_use;

  assign access   = (EXMEM_MemRead != 2'd0) || (EXMEM_MemWrite != 2'd0);
  assign pending  = access && !MemReady;
  assign load_use = (IDEX_MemRead != 2'd0) && (IDEX_Rt != 5'd0) &&
                    ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
  assign cnt_inc  = cnt_q + 8'd1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RUN: begin
        if (pending) begin
          state_d = MEM_WAIT;
          cnt_d   = 8'd1;
        end
      end
      MEM_WAIT: begin
        // A ready in the cycle the count would hit the limit still completes.
        if (MemReady) begin
          state_d = RUN;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_inc;
          if (int'(cnt_inc) >= MEM_TIMEOUT) state_d = ERROR;
        end
      end
      ERROR:   state_d = ERROR;
      default: begin
        state_d = RUN;
        cnt_d   = 8'd0;
      end
    endcase
  end

  always_comb begin
    PCWrite    = 1'b1;
    IFIDWrite  = 1'b1;
    IFIDFlush  = 1'b0;
    IDEXBubble = 1'b0;
    IDEXHold   = 1'b0;
    EXMEMHold  = 1'b0;
    if (!Reset) begin
      if ((state_q == ERROR) ||
          ((state_q == RUN) && pending) ||
          ((state_q == MEM_WAIT) && !MemReady)) begin
        PCWrite   = 1'b0;
        IFIDWrite = 1'b0;
        IDEXHold  = 1'b1;
        EXMEMHold = 1'b1;
      end else if (load_use) begin
        // Suppresses any branch this cycle; it is re-seen once the bubble moves on.
        PCWrite    = 1'b0;
        IFIDWrite  = 1'b0;
        IDEXBubble = 1'b1;
      end else if (BranchTaken) begin
        IFIDFlush = 1'b1;
      end
    end
  end

  assign MemError = (state_q == ERROR);
  assign State    = state_q;

`ifdef HAZ_STALL_CNT_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= 16'd0;
    end else if (!PCWrite && (StallCount != 16'hFFFF)) begin
      StallCount <= StallCount + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16, max wait cycles for data-memory ready before error (legal 2..255).
REQ-002 Clk  in  1  rising-edge clock.
REQ-003 Reset  in  1  asynchronous, active-high reset.
REQ-004 IFID_Rs, IFID_Rt  in  5 each  source regs of instruction in ID.
REQ-005 IDEX_MemRead  in  2  ID/EX load size (0 = no load); IDEX_Rt  in  5  load destination.
REQ-006 BranchTaken  in  1  branch resolved taken in ID this cycle.
REQ-007 EXMEM_MemRead, EXMEM_MemWrite  in  2 each  MEM-stage access size (0 = none).
REQ-008 MemReady  in  1  data memory completes MEM-stage access this cycle.
REQ-009 PCWrite, IFIDWrite  out  1  enable PC / IF-ID register update.
REQ-010 IFIDFlush  out  1  zero IF/ID contents; IDEXBubble  out  1  load control zeros into ID/EX.
REQ-011 IDEXHold, EXMEMHold  out  1  freeze ID/EX, EX/MEM registers.
REQ-012 MemError  out  1  sticky timeout flag; State  out  2  current FSM state.

Function
REQ-013 States SHALL be RUN=0, MEM_WAIT=1, ERROR=2; State SHALL be registered, outputs combinational from State and inputs.
REQ-014 Pending SHALL mean (EXMEM_MemRead!=0 or EXMEM_MemWrite!=0) and MemReady=0.
REQ-015 LoadUse SHALL mean IDEX_MemRead!=0 and IDEX_Rt!=0 and IDEX_Rt equals IFID_Rs or IFID_Rt.
REQ-016 Freeze SHALL mean PCWrite=0, IFIDWrite=0, IDEXHold=1, EXMEMHold=1, IFIDFlush=0, IDEXBubble=0.
REQ-017 RUN, Pending: Freeze same cycle; next state MEM_WAIT; wait counter loads 1.
REQ-018 RUN, no Pending, LoadUse: PCWrite=0, IFIDWrite=0, IDEXBubble=1, holds deasserted, IFIDFlush=0; stay RUN (exactly one bubble per hazard).
REQ-019 RUN, no Pending, no LoadUse, BranchTaken: IFIDFlush=1, PCWrite=1, IFIDWrite=1, others 0.
REQ-020 RUN otherwise: PCWrite=1, IFIDWrite=1, all other controls 0.
REQ-021 Priority SHALL be Pending > LoadUse > BranchTaken; a suppressed branch is re-evaluated when its instruction remains in ID.
REQ-022 MEM_WAIT, MemReady=0: Freeze; counter increments (8-bit); when counter reaches MEM_TIMEOUT next state ERROR.
REQ-023 MEM_WAIT, MemReady=1: outputs per RUN rules with Pending treated false; next state RUN; counter clears.
REQ-024 MemReady=1 in the same cycle the counter reaches MEM_TIMEOUT SHALL complete normally (ready wins).
REQ-025 ERROR: Freeze permanently, MemError=1; exit only by Reset.
REQ-026 MemReady when no access requested SHALL be ignored.

Reset
REQ-027 Reset SHALL asynchronously force State=RUN, counter=0, MemError=0, StallCount=0, mid-wait included.
REQ-028 While Reset=1 outputs SHALL be PCWrite=1, IFIDWrite=1, all other controls 0.

Configuration
REQ-029 Macro HAZ_STALL_CNT_EN defined: add output StallCount (16 bits), increments each cycle PCWrite=0 outside Reset, saturates at 0xFFFF.
REQ-030 Macro undefined: StallCount port and logic SHALL be absent; all other behaviour identical.

Verification
REQ-031 IDEX_MemRead=2, IDEX_Rt=8, IFID_Rs=8 -> one cycle PCWrite=0, IDEXBubble=1; next cycle (bubble in ID/EX) PCWrite=1.
REQ-032 IDEX_MemRead=2, IDEX_Rt=0, IFID_Rs=0 -> no stall, PCWrite=1.
REQ-033 EXMEM_MemRead=2, MemReady low 3 cycles then high -> Freeze 3 cycles, State=1, release on 4th, State=0.
REQ-034 EXMEM_MemWrite=1, MemReady never high, MEM_TIMEOUT=16 -> State=2, MemError=1 after 16 frozen cycles; stays until Reset.
REQ-035 LoadUse and BranchTaken same cycle -> IDEXBubble=1, IFIDFlush=0; next cycle BranchTaken alone -> IFIDFlush=1.
REQ-036 Reset asserted mid MEM_WAIT -> immediate State=0, PCWrite=1, MemError=0; with HAZ_STALL_CNT_EN, StallCount=0.
